// File: rtl/pipe_mem_pkg.sv
// Shared types and default widths for the IF/MEM unified-memory arbiter.
package pipe_mem_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/pipe_mem_pick.sv
// Combinational winner selection: data first, fetch forced once starvation saturates.
module pipe_mem_pick
    import pipe_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int SW         = 3
) (
    input  logic          d_req,
    input  logic          if_req,
    input  logic          if_flush,
    input  logic [SW-1:0] starve_cnt,
    output owner_t        winner
);
    logic fetch_ok;
    logic starved;

    always_comb begin
        // A redirecting fetch is never granted; the new address arrives next cycle.
        fetch_ok = if_req & ~if_flush;
        starved  = (starve_cnt == SW'(STARVE_MAX));
        winner   = OWN_NONE;
        if (fetch_ok && starved) begin
            winner = OWN_IF;
        end else if (d_req) begin
            winner = OWN_D;
        end else if (fetch_ok) begin
            winner = OWN_IF;
        end
    end
endmodule

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store, one transaction per MEM_LAT cycles.
// state | meaning
// IDLE  | no transaction in flight
// BUSY  | transaction in flight, lat_cnt runs 1..MEM_LAT, response when lat_cnt == MEM_LAT
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_t    state, state_nxt;
    owner_t        owner, owner_nxt, winner;
    logic [3:0]    lat_cnt, lat_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          cancel, cancel_nxt;
    logic          owner_we, owner_we_nxt;
    logic          final_cyc, can_grant, grant_if, grant_d, resp;

    pipe_mem_pick #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_pick (
        .d_req      (d_req),
        .if_req     (if_req),
        .if_flush   (if_flush),
        .starve_cnt (starve_cnt),
        .winner     (winner)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            cancel     <= 1'b0;
            owner_we   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            lat_cnt    <= lat_nxt;
            starve_cnt <= starve_nxt;
            cancel     <= cancel_nxt;
            owner_we   <= owner_we_nxt;
        end
    end

    always_comb begin
        final_cyc = (state == BUSY) && (lat_cnt == 4'(MEM_LAT));
        // Reset gates every combinational output so the port is quiet while held in reset.
        can_grant = reset && ((state == IDLE) || final_cyc);
        grant_if  = can_grant && (winner == OWN_IF);
        grant_d   = can_grant && (winner == OWN_D);
        resp      = reset && final_cyc;

        state_nxt    = state;
        owner_nxt    = owner;
        lat_nxt      = lat_cnt;
        cancel_nxt   = cancel;
        owner_we_nxt = owner_we;

        if (grant_if || grant_d) begin
            state_nxt    = BUSY;
            lat_nxt      = 4'd1;
            owner_nxt    = winner;
            owner_we_nxt = grant_d && d_we;
            cancel_nxt   = 1'b0;
        end else if (final_cyc) begin
            state_nxt    = IDLE;
            lat_nxt      = '0;
            owner_nxt    = OWN_NONE;
            owner_we_nxt = 1'b0;
            cancel_nxt   = 1'b0;
        end else if (state == BUSY) begin
            lat_nxt    = lat_cnt + 4'd1;
            cancel_nxt = cancel | ((owner == OWN_IF) && if_flush);
        end

        starve_nxt = starve_cnt;
        if (!if_req || grant_if) begin
            starve_nxt = '0;
        end else if (grant_d && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        mem_en    = grant_if | grant_d;
        mem_we    = grant_d & d_we;
        mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
        mem_wdata = grant_d ? d_wdata : '0;
        mem_be    = (grant_d && d_we) ? d_be : '0;

        // The response cycle of a cancelled fetch still occupies the port but stays silent.
        if_rvalid = resp && (owner == OWN_IF) && !cancel && !if_flush;
        d_rvalid  = resp && (owner == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !owner_we) ? mem_rdata : '0;

        if_stall  = reset & if_req & ~if_rvalid & ~if_flush;
        d_stall   = reset & d_req & ~d_rvalid;
    end
endmodule
